// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus bundle: redirect/stall from the pipeline, the instruction
// memory handshake, and the one-entry decode buffer outputs.
interface fetch_ctrl_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  modport master (
    input  redirect_valid, redirect_pc, stall, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, if_valid, if_pc, if_inst
  );

  modport slave (
    output redirect_valid, redirect_pc, stall, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_pc, if_inst
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, one-entry
// decode buffer, redirect flush with wrong-path response squashing.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_KILL} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;

  logic        req;
  logic [31:0] redir_tgt;

  assign redir_tgt     = {bus.redirect_pc[31:2], 2'b00};
  // Only request when the buffer can take the response without overwriting.
  assign req           = (state_q == S_REQ) && (!if_valid_q || !bus.stall) && !rst;
  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_inst   = if_inst_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;

    if (if_valid_q && !bus.stall) if_valid_d = 1'b0;

    unique case (state_q)
      S_REQ: begin
        if (req && bus.imem_gnt) begin
          if (bus.redirect_valid) begin
            pc_d    = redir_tgt;
            state_d = S_KILL;
          end else begin
            pend_d  = pc_q;
            pc_d    = pc_q + 32'd4;
            state_d = S_WAIT;
          end
        end else if (bus.redirect_valid) begin
          pc_d = redir_tgt;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          state_d = S_REQ;
          if (bus.redirect_valid) begin
            pc_d = redir_tgt;
          end else begin
            if_valid_d = 1'b1;
            if_pc_d    = pend_q;
            if_inst_d  = bus.imem_rdata;
          end
        end else if (bus.redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = S_KILL;
        end
      end
      S_KILL: begin
        if (bus.redirect_valid) pc_d = redir_tgt;
        if (bus.imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (bus.redirect_valid) if_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      pend_q     <= 32'd0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'd0;
      if_inst_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, then random traffic against a
// transaction-level model of the fetch stream and a latency-varying memory.
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_ctrl_if bus();
  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [31:0] mf(input logic [31:0] a);
    return a ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int cyc);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, stall, gnt, rdr;
    logic [31:0] rpc;
    logic        rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  function automatic vec_t mk(input logic r, s, g, d, input logic [31:0] rpc, input logic rv,
                              input logic [31:0] rd, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep, ei);
    vec_t v;
    v.rst = r; v.stall = s; v.gnt = g; v.rdr = d; v.rpc = rpc; v.rv = rv; v.rdata = rd;
    v.e_req = er; v.e_addr = ea; v.e_v = ev; v.e_pc = ep; v.e_inst = ei;
    return v;
  endfunction

  task automatic drive(input logic r, s, g, d, input logic [31:0] rpc, input logic rv, input logic [31:0] rd);
    rst = r; bus.stall = s; bus.imem_gnt = g; bus.redirect_valid = d;
    bus.redirect_pc = rpc; bus.imem_rvalid = rv; bus.imem_rdata = rd;
  endtask

  vec_t tbl[26];

  // reference model state
  logic [31:0] m_pc, m_pend, m_bpc, m_binst;
  logic        m_busy, m_wrong, m_bv;
  // memory model state
  logic        mem_pend;
  int          mem_lat;
  logic [31:0] mem_addr;

  initial begin
    logic [31:0] m8;
    logic        r, s, g, d, rv, e_req, fire, resp;
    logic [31:0] rpc, rd;

    m8 = mf(32'h8);
    tbl[0]  = mk(1,0,0,0,0,0,0,            0,32'h0,0,0,0);
    tbl[1]  = mk(0,0,1,0,0,0,0,            1,32'h0,0,0,0);
    tbl[2]  = mk(0,0,1,0,0,1,mf(32'h0),    0,32'h4,0,0,0);
    tbl[3]  = mk(0,0,1,0,0,0,0,            1,32'h4,1,32'h0,mf(32'h0));
    tbl[4]  = mk(0,0,1,0,0,1,mf(32'h4),    0,32'h8,0,32'h0,mf(32'h0));
    tbl[5]  = mk(0,0,1,0,0,0,0,            1,32'h8,1,32'h4,mf(32'h4));
    tbl[6]  = mk(0,0,1,0,0,1,m8,           0,32'hC,0,32'h4,mf(32'h4));
    for (int i = 7; i <= 11; i++)
      tbl[i] = mk(0,1,1,0,0,0,0,           0,32'hC,1,32'h8,m8);
    tbl[12] = mk(0,0,1,0,0,0,0,            1,32'hC,1,32'h8,m8);
    tbl[13] = mk(0,0,0,1,32'h103,0,0,      0,32'h10,0,32'h8,m8);
    tbl[14] = mk(0,0,0,0,0,0,0,            0,32'h100,0,32'h8,m8);
    tbl[15] = mk(0,0,0,0,0,1,mf(32'hC),    0,32'h100,0,32'h8,m8);
    tbl[16] = mk(0,0,1,0,0,0,0,            1,32'h100,0,32'h8,m8);
    tbl[17] = mk(0,0,0,1,32'h200,1,mf(32'h100), 0,32'h104,0,32'h8,m8);
    tbl[18] = mk(0,0,1,1,32'h300,0,0,      1,32'h200,0,32'h8,m8);
    tbl[19] = mk(0,0,0,0,0,1,mf(32'h200),  0,32'h300,0,32'h8,m8);
    tbl[20] = mk(0,0,0,1,32'hFFFF_FFFF,0,0, 1,32'h300,0,32'h8,m8);
    tbl[21] = mk(0,0,1,0,0,0,0,            1,32'hFFFF_FFFC,0,32'h8,m8);
    tbl[22] = mk(0,0,0,0,0,1,mf(32'hFFFF_FFFC), 0,32'h0,0,32'h8,m8);
    tbl[23] = mk(0,0,1,0,0,0,0,            1,32'h0,1,32'hFFFF_FFFC,mf(32'hFFFF_FFFC));
    tbl[24] = mk(1,0,1,0,0,0,0,            0,32'h4,0,32'hFFFF_FFFC,mf(32'hFFFF_FFFC));
    tbl[25] = mk(0,0,0,0,0,0,0,            1,32'h0,0,32'h0,32'h0);

    drive(1,0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].gnt, tbl[i].rdr, tbl[i].rpc, tbl[i].rv, tbl[i].rdata);
      @(negedge clk);
      chk("vec_req",   {31'd0, bus.imem_req}, {31'd0, tbl[i].e_req}, i);
      chk("vec_addr",  bus.imem_addr, tbl[i].e_addr, i);
      chk("vec_valid", {31'd0, bus.if_valid}, {31'd0, tbl[i].e_v}, i);
      chk("vec_pc",    bus.if_pc, tbl[i].e_pc, i);
      chk("vec_inst",  bus.if_inst, tbl[i].e_inst, i);
      @(posedge clk);
      #1;
    end

    // random phase
    mem_pend = 0; mem_lat = 0; mem_addr = 0;
    m_pc = 0; m_pend = 0; m_bpc = 0; m_binst = 0; m_busy = 0; m_wrong = 0; m_bv = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r   = (cyc < 2) || ($urandom_range(0, 299) == 0);
      s   = ($urandom_range(0, 2) == 0);
      g   = ($urandom_range(0, 2) != 0);
      d   = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rv  = mem_pend && (mem_lat == 0);
      if (!rv && !m_busy && ($urandom_range(0, 15) == 0)) rv = 1'b1;
      rd  = (mem_pend && mem_lat == 0) ? mf(mem_addr) : $urandom;
      drive(r, s, g, d, rpc, rv, rd);
      @(negedge clk);
      e_req = !r && !m_busy && (!m_bv || !s);
      chk("rnd_req",   {31'd0, bus.imem_req}, {31'd0, e_req}, cyc);
      chk("rnd_addr",  bus.imem_addr, m_pc, cyc);
      chk("rnd_valid", {31'd0, bus.if_valid}, {31'd0, m_bv}, cyc);
      chk("rnd_pc",    bus.if_pc, m_bpc, cyc);
      chk("rnd_inst",  bus.if_inst, m_binst, cyc);

      // memory side reacts to what the DUT actually presented
      if (r) mem_pend = 0;
      else begin
        if (mem_pend && mem_lat == 0) mem_pend = 0;
        else if (mem_pend) mem_lat--;
        if (bus.imem_req && g) begin
          mem_pend = 1; mem_lat = $urandom_range(0, 2); mem_addr = bus.imem_addr;
        end
      end

      // reference: fetch stream advances by 4, redirects squash everything in flight
      if (r) begin
        m_pc = 0; m_pend = 0; m_bpc = 0; m_binst = 0; m_busy = 0; m_wrong = 0; m_bv = 0;
      end else begin
        fire = e_req && g;
        resp = m_busy && rv;
        if (m_bv && !s) m_bv = 0;
        if (resp && !m_wrong && !d) begin
          m_bv = 1; m_bpc = m_pend; m_binst = mf(m_pend);
        end
        if (resp) m_busy = 0;
        if (fire) begin
          m_busy = 1; m_wrong = 0; m_pend = m_pc; m_pc = m_pc + 32'd4;
        end
        if (d) begin
          m_pc = {rpc[31:2], 2'b00};
          m_bv = 0;
          if (m_busy) m_wrong = 1;
        end
      end
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset (word-aligned).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 redirect_valid  input  1  branch/jump/trap redirect request, single-cycle pulse, highest priority.
REQ-005 redirect_pc  input  32  redirect target; bits [1:0] ignored, forced to 2'b00.
REQ-006 stall  input  1  decode not ready; when high, buffered instruction is held.
REQ-007 imem_req  output  1  instruction memory request valid.
REQ-008 imem_addr  output  32  instruction memory address; equals internal fetch pc.
REQ-009 imem_gnt  input  1  memory accepts request in the cycle where imem_req && imem_gnt.
REQ-010 imem_rvalid  input  1  response valid, earliest one cycle after grant.
REQ-011 imem_rdata  input  32  response instruction word.
REQ-012 if_valid  output  1  instruction buffer holds a valid instruction for decode.
REQ-013 if_pc  output  32  pc of the buffered instruction.
REQ-014 if_inst  output  32  buffered instruction word.

Function
REQ-015 Single outstanding memory request; states REQ, WAIT, KILL; one-entry output buffer (if_valid/if_pc/if_inst registers).
REQ-016 Buffer consumed in any cycle with if_valid=1 && stall=0; if_valid clears that edge unless refilled the same edge.
REQ-017 imem_req = (state==REQ) && (!if_valid || !stall) && !rst; combinational, no dependency on redirect_valid.
REQ-018 REQ, grant, no redirect: latch fetch pc as pending pc, pc <= pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go WAIT.
REQ-019 REQ, grant and redirect same cycle: pc <= redirect target, go KILL (accepted request becomes wrong-path).
REQ-020 REQ, no grant, redirect: pc <= redirect target, stay REQ; imem_addr may change while imem_req high and ungranted.
REQ-021 WAIT, rvalid, no redirect: if_inst <= imem_rdata, if_pc <= pending pc, if_valid <= 1, go REQ.
REQ-022 WAIT, rvalid and redirect same cycle: discard rdata, pc <= redirect target, go REQ.
REQ-023 WAIT, redirect, no rvalid: pc <= redirect target, go KILL.
REQ-024 KILL: imem_req=0; on rvalid discard rdata, go REQ; redirect in KILL updates pc, stays KILL (or goes REQ if rvalid same cycle).
REQ-025 Any redirect clears if_valid at that edge (flush), regardless of stall.
REQ-026 imem_rvalid in state REQ is ignored; buffer never overwritten while if_valid=1 && stall=1 (guaranteed by REQ-017).
REQ-027 if_valid, if_pc, if_inst registered; no combinational path from imem_rdata to if_* outputs.
REQ-028 Throughput with 1-cycle memory and no stall: one instruction every 2 cycles.

Reset
REQ-029 rst high at an edge: state <= REQ, pc <= RESET_PC, if_valid <= 0, if_pc <= 0, if_inst <= 0, pending pc <= 0.
REQ-030 While rst high, imem_req = 0; first request (addr RESET_PC) in the first cycle after rst deasserts.
REQ-031 Reset mid-transaction abandons the outstanding request; memory is reset by the same rst, so no stale rvalid follows.

Verification
REQ-032 Reset, RESET_PC=0, gnt always 1, rvalid 1 cycle after gnt, stall=0 -> imem_addr 0,4,8,...; if_pc 0,4,8 each with if_valid 1 every other cycle; if_inst matches memory.
REQ-033 Buffer valid with if_pc=8, stall held 5 cycles -> imem_req=0, if_pc/if_inst stable 5 cycles; stall drop -> request addr 0xC issued same cycle.
REQ-034 Redirect to 32'h0000_0103 in WAIT, rvalid 2 cycles later -> response discarded, if_valid stays 0, next imem_addr 0x100.
REQ-035 Redirect and rvalid same cycle in WAIT -> no if_valid, next imem_addr = redirect target; redirect and gnt same cycle in REQ -> KILL, following rvalid dropped.
REQ-036 pc 32'hFFFF_FFFC fetched -> next imem_addr 0; rst asserted during WAIT -> next cycle imem_req=0, if_valid=0, after release imem_addr=RESET_PC.
